// File: rtl/irq_entry.sv
// rtl/irq_entry.sv - interrupt entry sequencer: prioritise request, push CPU state, fetch vector
module irq_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_req,
  input  logic [4:0]  irq_vector,
  input  logic [1:0]  cpu_i01,
  input  logic        instr_boundary,
  input  logic [15:0] pc,
  input  logic [7:0]  cb,
  input  logic [7:0]  sc,
  input  logic [15:0] sp,
  output logic [23:0] bus_address_out,
  output logic [7:0]  bus_data_out,
  output logic        bus_write,
  output logic        bus_read,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_ack,
  output logic        busy,
  output logic        irq_ack,
  output logic [4:0]  ack_vector,
  output logic [15:0] new_pc,
  output logic [15:0] new_sp,
  output logic [1:0]  new_i01
);

  typedef enum logic [2:0] {
    IDLE, PUSH_CB, PUSH_PCH, PUSH_PCL, PUSH_SC, RD_VL, RD_VH, DONE
  } state_t;

  state_t      state;
  logic [4:0]  vec_q;
  logic [15:0] pc_q;
  logic [7:0]  sc_q;
  logic [15:0] sp_q;
  logic [1:0]  i01_q;
  logic [7:0]  vl_q;

  logic [1:0]  req_lvl;
  logic        take;

  // Level 0 here means no maskable request is pending.
  always_comb begin
    req_lvl = 2'd0;
    if (irq_req[2])      req_lvl = 2'd3;
    else if (irq_req[1]) req_lvl = 2'd2;
    else if (irq_req[0]) req_lvl = 2'd1;
  end

  assign take = (state == IDLE) && instr_boundary && (irq_req[3] || (req_lvl > cpu_i01));
  assign busy = (state != IDLE);

  function automatic logic [23:0] stack_addr(input logic [15:0] base, input logic [15:0] k);
    logic [15:0] a;
    a = base - k;
    return {8'h00, a};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      vec_q           <= '0;
      pc_q            <= '0;
      sc_q            <= '0;
      sp_q            <= '0;
      i01_q           <= '0;
      vl_q            <= '0;
      bus_address_out <= '0;
      bus_data_out    <= '0;
      bus_write       <= 1'b0;
      bus_read        <= 1'b0;
      irq_ack         <= 1'b0;
      ack_vector      <= '0;
      new_pc          <= '0;
      new_sp          <= '0;
      new_i01         <= '0;
    end else begin
      irq_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            vec_q           <= irq_vector;
            pc_q            <= pc;
            sc_q            <= sc;
            sp_q            <= sp;
            i01_q           <= irq_req[3] ? 2'd3 : req_lvl;
            bus_write       <= 1'b1;
            bus_address_out <= stack_addr(sp, 16'd1);
            bus_data_out    <= cb;
            state           <= PUSH_CB;
          end
        end
        PUSH_CB: begin
          if (bus_ack) begin
            bus_address_out <= stack_addr(sp_q, 16'd2);
            bus_data_out    <= pc_q[15:8];
            state           <= PUSH_PCH;
          end
        end
        PUSH_PCH: begin
          if (bus_ack) begin
            bus_address_out <= stack_addr(sp_q, 16'd3);
            bus_data_out    <= pc_q[7:0];
            state           <= PUSH_PCL;
          end
        end
        PUSH_PCL: begin
          if (bus_ack) begin
            bus_address_out <= stack_addr(sp_q, 16'd4);
            bus_data_out    <= sc_q;
            state           <= PUSH_SC;
          end
        end
        PUSH_SC: begin
          if (bus_ack) begin
            bus_write       <= 1'b0;
            bus_read        <= 1'b1;
            bus_address_out <= {18'd0, vec_q, 1'b0};
            bus_data_out    <= 8'h00;
            state           <= RD_VL;
          end
        end
        RD_VL: begin
          if (bus_ack) begin
            vl_q            <= bus_data_in;
            bus_address_out <= {18'd0, vec_q, 1'b1};
            state           <= RD_VH;
          end
        end
        RD_VH: begin
          if (bus_ack) begin
            bus_read        <= 1'b0;
            bus_address_out <= '0;
            new_pc          <= {bus_data_in, vl_q};
            new_sp          <= sp_q - 16'd4;
            new_i01         <= i01_q;
            ack_vector      <= vec_q;
            irq_ack         <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_entry.sv
// tb/tb_irq_entry.sv - self-checking bench for irq_entry against a transaction-level model
module tb_irq_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_req = '0;
  logic [4:0]  irq_vector = '0;
  logic [1:0]  cpu_i01 = '0;
  logic        instr_boundary = 1'b0;
  logic [15:0] pc = '0;
  logic [7:0]  cb = '0;
  logic [7:0]  sc = '0;
  logic [15:0] sp = '0;
  logic [23:0] bus_address_out;
  logic [7:0]  bus_data_out;
  logic        bus_write;
  logic        bus_read;
  logic [7:0]  bus_data_in;
  logic        bus_ack = 1'b1;
  logic        busy;
  logic        irq_ack;
  logic [4:0]  ack_vector;
  logic [15:0] new_pc;
  logic [15:0] new_sp;
  logic [1:0]  new_i01;

  irq_entry dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .irq_vector(irq_vector),
    .cpu_i01(cpu_i01), .instr_boundary(instr_boundary), .pc(pc), .cb(cb),
    .sc(sc), .sp(sp), .bus_address_out(bus_address_out), .bus_data_out(bus_data_out),
    .bus_write(bus_write), .bus_read(bus_read), .bus_data_in(bus_data_in),
    .bus_ack(bus_ack), .busy(busy), .irq_ack(irq_ack), .ack_vector(ack_vector),
    .new_pc(new_pc), .new_sp(new_sp), .new_i01(new_i01)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  assign bus_data_in = bus_read ? mem[bus_address_out[7:0]] : 8'h00;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        w;
    logic [23:0] a;
    logic [7:0]  d;
  } op_t;

  // Model: an accepted request becomes a list of six bus operations; done follows the last one.
  int          m_phase;
  op_t         m_ops[$];
  logic [15:0] m_new_pc, m_new_sp, p_pc, p_sp;
  logic [1:0]  m_new_i01, p_i01;
  logic [4:0]  m_vec, p_vec;
  int          m_lvl;
  logic [7:0]  m_bytes [1:4];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_ops.delete();
      m_new_pc = '0; m_new_sp = '0; m_new_i01 = '0; m_vec = '0;
    end else begin
      case (m_phase)
        0: begin
          m_lvl = 0;
          for (int i = 0; i < 4; i++) if (irq_req[i]) m_lvl = i + 1;
          if (instr_boundary && (m_lvl == 4 || m_lvl > int'(cpu_i01))) begin
            m_bytes[1] = cb; m_bytes[2] = pc[15:8]; m_bytes[3] = pc[7:0]; m_bytes[4] = sc;
            for (int k = 1; k <= 4; k++)
              m_ops.push_back(op_t'{1'b1, {8'h00, 16'(sp - 16'(k))}, m_bytes[k]});
            m_ops.push_back(op_t'{1'b0, 24'(irq_vector) * 2, 8'h00});
            m_ops.push_back(op_t'{1'b0, 24'(irq_vector) * 2 + 1, 8'h00});
            p_pc  = {mem[8'(irq_vector) * 2 + 1], mem[8'(irq_vector) * 2]};
            p_sp  = sp - 16'd4;
            p_i01 = (m_lvl == 4) ? 2'd3 : 2'(m_lvl);
            p_vec = irq_vector;
            m_phase = 1;
          end
        end
        1: begin
          if (bus_ack) begin
            void'(m_ops.pop_front());
            if (m_ops.size() == 0) begin
              m_new_pc = p_pc; m_new_sp = p_sp; m_new_i01 = p_i01; m_vec = p_vec;
              m_phase = 2;
            end
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always begin
    @(negedge clk);
    #2;
    check("busy", busy, m_phase != 0);
    check("irq_ack", irq_ack, m_phase == 2);
    if (m_phase == 1) begin
      check("bus_write", bus_write, m_ops[0].w);
      check("bus_read", bus_read, !m_ops[0].w);
      check("bus_addr", bus_address_out, m_ops[0].a);
      if (m_ops[0].w) check("bus_wdata", bus_data_out, m_ops[0].d);
    end else begin
      check("strobes_off", {bus_write, bus_read}, 2'b00);
      if (m_phase == 0) check("idle_bus", {bus_address_out, bus_data_out}, 32'd0);
    end
    check("new_pc", new_pc, m_new_pc);
    check("new_sp", new_sp, m_new_sp);
    check("new_i01", new_i01, m_new_i01);
    check("ack_vector", ack_vector, m_vec);
  end

  logic [31:0] wlog[$];
  logic [23:0] rlog[$];
  always @(posedge clk) begin
    if (reset && bus_ack && bus_write) wlog.push_back({bus_address_out, bus_data_out});
    if (reset && bus_ack && bus_read)  rlog.push_back(bus_address_out);
  end

  // Called on a negedge; returns cycles from the accept cycle to irq_ack (-1 if none).
  task automatic run_irq(input logic [3:0] req, input logic [4:0] vec, input logic [1:0] i01,
                         input logic [15:0] a_sp, input logic [15:0] a_pc,
                         input logic [7:0] a_cb, input logic [7:0] a_sc,
                         input int stall_at, input int stall_len, input int reset_at,
                         output int lat);
    irq_req = req; irq_vector = vec; cpu_i01 = i01; sp = a_sp; pc = a_pc;
    cb = a_cb; sc = a_sc; instr_boundary = 1'b1; bus_ack = 1'b1;
    wlog.delete(); rlog.delete();
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      instr_boundary = 1'b0;
      irq_req = 4'b1000;
      irq_vector = 5'd9;
      sp = 16'hAAAA;
      bus_ack = (n >= stall_at && n < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (n == reset_at) begin
        check("read_before_reset", bus_read, 1'b1);
        reset = 1'b0;
        break;
      end
      if (irq_ack) begin
        lat = n;
        break;
      end
    end
    irq_req = 4'b0000;
    bus_ack = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  int lat, first_ack, second_ack;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
    mem[8'h06] = 8'h11; mem[8'h07] = 8'h22;
    mem[8'h0A] = 8'h78; mem[8'h0B] = 8'h56;
    mem[8'h3E] = 8'hBE; mem[8'h3F] = 8'hEF;

    idle_cycles(3);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_strobes", {bus_write, bus_read, irq_ack}, 3'b000);
    check("rst_bus", {bus_address_out, bus_data_out}, 32'd0);
    check("rst_new", {new_pc, new_sp}, 32'd0);
    check("rst_vec_i01", {ack_vector, new_i01}, 7'd0);
    @(negedge clk);
    reset = 1'b1;

    irq_req = 4'b0100;
    idle_cycles(3);
    #2 check("no_boundary_idle", busy, 1'b0);
    irq_req = 4'b0000;
    @(negedge clk);

    run_irq(4'b0010, 5'd5, 2'd1, 16'h1FF0, 16'h1234, 8'h02, 8'h40, 0, 0, 0, lat);
    check("lat_basic", 32'(lat), 32'd7);
    check("basic_new_pc", new_pc, 16'h5678);
    check("basic_new_sp", new_sp, 16'h1FEC);
    check("basic_new_i01", new_i01, 2'd2);
    check("basic_ack_vec", ack_vector, 5'd5);
    check("basic_nwrites", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("basic_w0", wlog[0], {24'h001FEF, 8'h02});
      check("basic_w1", wlog[1], {24'h001FEE, 8'h12});
      check("basic_w2", wlog[2], {24'h001FED, 8'h34});
      check("basic_w3", wlog[3], {24'h001FEC, 8'h40});
    end
    idle_cycles(2);

    irq_req = 4'b0001; cpu_i01 = 2'd1; instr_boundary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 check("masked_busy", busy, 1'b0);
    end
    instr_boundary = 1'b0; irq_req = 4'b0000;
    @(negedge clk);

    run_irq(4'b1001, 5'd3, 2'd3, 16'h4000, 16'hBEEF, 8'h5A, 8'hC3, 0, 0, 0, lat);
    check("lat_nmi", 32'(lat), 32'd7);
    check("nmi_new_i01", new_i01, 2'd3);
    check("nmi_new_pc", new_pc, 16'h2211);
    idle_cycles(2);

    run_irq(4'b0110, 5'd31, 2'd2, 16'h8000, 16'h0F0F, 8'h01, 8'h02, 0, 0, 0, lat);
    check("prio_new_i01", new_i01, 2'd3);
    check("prio_new_pc", new_pc, 16'hEFBE);
    check("prio_nreads", rlog.size(), 32'd2);
    if (rlog.size() == 2) begin
      check("prio_rd0", rlog[0], 24'h00003E);
      check("prio_rd1", rlog[1], 24'h00003F);
    end
    idle_cycles(2);

    run_irq(4'b0100, 5'd5, 2'd0, 16'h0002, 16'hA5C3, 8'h7E, 8'h81, 0, 0, 0, lat);
    check("wrap_new_sp", new_sp, 16'hFFFE);
    check("wrap_nwrites", wlog.size(), 32'd4);
    if (wlog.size() == 4) begin
      check("wrap_a0", wlog[0][31:8], 24'h000001);
      check("wrap_a1", wlog[1][31:8], 24'h000000);
      check("wrap_a2", wlog[2][31:8], 24'h00FFFF);
      check("wrap_a3", wlog[3][31:8], 24'h00FFFE);
    end
    idle_cycles(2);

    run_irq(4'b0010, 5'd5, 2'd0, 16'h1FF0, 16'h1234, 8'h02, 8'h40, 2, 3, 0, lat);
    check("lat_stall", 32'(lat), 32'd10);
    idle_cycles(2);

    run_irq(4'b0100, 5'd31, 2'd0, 16'h3000, 16'h1111, 8'h22, 8'h33, 0, 0, 5, lat);
    #2;
    check("rst_mid_strobes", {bus_write, bus_read}, 2'b00);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ack", irq_ack, 1'b0);
    check("rst_mid_new_pc", new_pc, 16'h0000);
    idle_cycles(2);
    reset = 1'b1;
    idle_cycles(6);

    first_ack = -1; second_ack = -1;
    irq_req = 4'b0100; cpu_i01 = 2'd0; irq_vector = 5'd5; sp = 16'h1FF0;
    instr_boundary = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (irq_ack) begin
        if (first_ack < 0) first_ack = n;
        else if (second_ack < 0) second_ack = n;
      end
    end
    instr_boundary = 1'b0; irq_req = 4'b0000;
    check("b2b_first", 32'(first_ack), 32'd7);
    check("b2b_gap", 32'(second_ack - first_ack), 32'd8);
    idle_cycles(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
